// File: rtl/checksum_accumulator.sv
// Sums one frame of partial checksum terms, folds with end-around carry to 16 bits,
// and presents the result on a valid/ready handshake. Define CHKSUM_INVERT_EN for ones'-complement output.
module checksum_accumulator #(
  parameter int IN_DATA_WIDTH  = 21,
  parameter int ACC_WIDTH      = 24,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_data_vld,
  input  logic [IN_DATA_WIDTH-1:0]  in_data,
  input  logic                      in_last,
  output logic                      in_rdy,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      out_data_vld,
  input  logic                      out_data_rdy,
  output logic [CNT_WIDTH-1:0]      term_cnt,
  output logic                      acc_ovf,
  output logic                      drop_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FOLD1 = 3'd2,
    FOLD2 = 3'd3,
    HOLD  = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic [OUT_DATA_WIDTH:0]   s1_q, s1_d;
  logic [OUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                      out_vld_q, out_vld_d;
  logic [CNT_WIDTH-1:0]      term_cnt_q, term_cnt_d;
  logic                      acc_ovf_q, acc_ovf_d;
  logic                      drop_err_q, drop_err_d;
  logic                      rdy_en_q, rdy_en_d;

  logic                      in_rdy_s;
  logic                      accept_s;
  logic [ACC_WIDTH:0]        sum_s;
  logic [OUT_DATA_WIDTH:0]   fold1_s;
  logic [OUT_DATA_WIDTH-1:0] fold2_s;

  // Next-state, datapath and handshake decode
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    s1_d       = s1_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    term_cnt_d = term_cnt_q;
    acc_ovf_d  = acc_ovf_q;
    drop_err_d = drop_err_q;
    rdy_en_d   = 1'b1;

    // rdy_en_q keeps in_rdy low while reset is held, since IDLE alone would read as ready
    in_rdy_s = rdy_en_q && ((state_q == IDLE) || (state_q == ACCUM));
    accept_s = in_data_vld && in_rdy_s;
    sum_s    = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(in_data);
    fold1_s  = (OUT_DATA_WIDTH+1)'(acc_q[OUT_DATA_WIDTH-1:0])
             + (OUT_DATA_WIDTH+1)'(acc_q[ACC_WIDTH-1:OUT_DATA_WIDTH]);
    fold2_s  = s1_q[OUT_DATA_WIDTH-1:0] + OUT_DATA_WIDTH'(s1_q[OUT_DATA_WIDTH]);

    if (in_data_vld && !in_rdy_s) begin
      drop_err_d = 1'b1;
    end else begin
      drop_err_d = drop_err_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          acc_d      = ACC_WIDTH'(in_data);
          term_cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          acc_ovf_d  = 1'b0;
          state_d    = in_last ? FOLD1 : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          acc_d = sum_s[ACC_WIDTH-1:0];
          if (sum_s[ACC_WIDTH]) begin
            acc_ovf_d = 1'b1;
          end else begin
            acc_ovf_d = acc_ovf_q;
          end
          if (term_cnt_q != {CNT_WIDTH{1'b1}}) begin
            term_cnt_d = term_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end else begin
            term_cnt_d = term_cnt_q;
          end
          state_d = in_last ? FOLD1 : ACCUM;
        end else begin
          state_d = ACCUM;
        end
      end
      FOLD1: begin
        s1_d    = fold1_s;
        state_d = FOLD2;
      end
      FOLD2: begin
`ifdef CHKSUM_INVERT_EN
        out_data_d = ~fold2_s;
`else
        out_data_d = fold2_s;
`endif
        out_vld_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (out_vld_q && out_data_rdy) begin
          out_vld_d  = 1'b0;
          acc_d      = {ACC_WIDTH{1'b0}};
          term_cnt_d = {CNT_WIDTH{1'b0}};
          acc_ovf_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= {ACC_WIDTH{1'b0}};
      s1_q       <= {(OUT_DATA_WIDTH+1){1'b0}};
      out_data_q <= {OUT_DATA_WIDTH{1'b0}};
      out_vld_q  <= 1'b0;
      term_cnt_q <= {CNT_WIDTH{1'b0}};
      acc_ovf_q  <= 1'b0;
      drop_err_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      s1_q       <= s1_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      term_cnt_q <= term_cnt_d;
      acc_ovf_q  <= acc_ovf_d;
      drop_err_q <= drop_err_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

  assign in_rdy       = in_rdy_s;
  assign out_data     = out_data_q;
  assign out_data_vld = out_vld_q;
  assign term_cnt     = term_cnt_q;
  assign acc_ovf      = acc_ovf_q;
  assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_checksum_accumulator.sv
// Scoreboard bench for checksum_accumulator: directed frames from the test plan plus
// randomized frames checked against an arithmetic reference model.
module tb_checksum_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_data_vld = 1'b0;
  logic [20:0] in_data = 21'd0;
  logic        in_last = 1'b0;
  logic        in_rdy;
  logic [15:0] out_data;
  logic        out_data_vld;
  logic        out_data_rdy = 1'b1;
  logic [7:0]  term_cnt;
  logic        acc_ovf;
  logic        drop_err;

  checksum_accumulator dut (
    .clk(clk), .reset(reset), .in_data_vld(in_data_vld), .in_data(in_data),
    .in_last(in_last), .in_rdy(in_rdy), .out_data(out_data), .out_data_vld(out_data_vld),
    .out_data_rdy(out_data_rdy), .term_cnt(term_cnt), .acc_ovf(acc_ovf), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] o;
    logic [7:0]  c;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] fin(input logic [15:0] x);
`ifdef CHKSUM_INVERT_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  // Drive one frame; expected result comes from the model unless use_exp supplies it.
  task automatic send_frame(input logic [20:0] terms[$], input bit gaps, input bit use_exp,
                            input logic [15:0] e_out, input logic [7:0] e_cnt, input logic e_ovf);
    longint unsigned total = 0;
    longint unsigned x;
    exp_t e;
    int t;
    for (int i = 0; i < terms.size(); i++) begin
      @(negedge clk);
      t = 0;
      while (!in_rdy && t < 100) begin
        in_data_vld = 1'b0;
        @(negedge clk);
        t++;
      end
      if (!in_rdy) chk("rdy_timeout", {31'd0, in_rdy}, 32'd1);
      in_data_vld = 1'b1;
      in_data     = terms[i];
      in_last     = (i == terms.size() - 1);
      @(posedge clk);
      #1;
      total += terms[i];
      if (gaps && i != terms.size() - 1 && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_data_vld = 1'b0;
        in_last     = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    e.cyc = cyc;
    if (use_exp) begin
      e.o = e_out; e.c = e_cnt; e.ovf = e_ovf;
    end else begin
      x = total % (64'd1 << 24);
      e.ovf = (total >= (64'd1 << 24));
      while (x > 64'hFFFF) x = (x & 64'hFFFF) + (x >> 16);
      e.o = fin(x[15:0]);
      e.c = (terms.size() > 255) ? 8'd255 : 8'(terms.size());
    end
    exp_q.push_back(e);
    @(negedge clk);
    in_data_vld = 1'b0;
    in_last     = 1'b0;
    chk("rdy_low_fold1", {31'd0, in_rdy}, 32'd0);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: latency on each valid rise, result compare on each handshake
  initial begin
    bit prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_data_vld && !prev) begin
        if (exp_q.size() == 0) chk("unexpected_vld", {31'd0, out_data_vld}, 32'd0);
        else chk("latency", cyc - exp_q[0].cyc, 32'd2);
      end
      if (out_data_vld && out_data_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {31'd0, out_data_vld}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {16'd0, out_data}, {16'd0, e.o});
          chk("term_cnt", {24'd0, term_cnt}, {24'd0, e.c});
          chk("acc_ovf", {31'd0, acc_ovf}, {31'd0, e.ovf});
        end
      end
      prev = out_data_vld;
    end
  end

  // Randomized downstream backpressure
  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) out_data_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [20:0] terms[$];
    logic [15:0] held;
    int t;

    repeat (3) @(negedge clk);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_vld", {31'd0, out_data_vld}, 32'd0);
    chk("rst_cnt", {24'd0, term_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, acc_ovf}, 32'd0);
    chk("rst_drop", {31'd0, drop_err}, 32'd0);
    chk("rst_rdy", {31'd0, in_rdy}, 32'd0);
    reset = 1'b1;
    #1 chk("rdy_before_edge", {31'd0, in_rdy}, 32'd0);
    @(negedge clk);
    chk("rdy_after_release", {31'd0, in_rdy}, 32'd1);

    terms = '{21'h00FFFF, 21'h000001};
    send_frame(terms, 1'b0, 1'b1, fin(16'h0001), 8'd2, 1'b0);
    terms = '{21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF};
    send_frame(terms, 1'b0, 1'b1, fin(16'h005D), 8'd3, 1'b0);
    terms.delete();
    for (int i = 0; i < 9; i++) terms.push_back(21'h1FFFFF);
    send_frame(terms, 1'b0, 1'b1, fin(16'h0017), 8'd9, 1'b1);
    drain();

    // Backpressure with terms offered during HOLD
    chk("drop_clear", {31'd0, drop_err}, 32'd0);
    out_data_rdy = 1'b0;
    terms = '{21'h000010, 21'h000020};
    send_frame(terms, 1'b0, 1'b1, fin(16'h0030), 8'd2, 1'b0);
    t = 0;
    while (!out_data_vld && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("vld_timeout", {31'd0, out_data_vld}, 32'd1);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_vld", {31'd0, out_data_vld}, 32'd1);
      chk("hold_data", {16'd0, out_data}, {16'd0, held});
      chk("hold_rdy", {31'd0, in_rdy}, 32'd0);
      if (i > 0) chk("drop_set", {31'd0, drop_err}, 32'd1);
      in_data_vld = 1'b1;
    end
    @(negedge clk);
    out_data_rdy = 1'b1;
    @(negedge clk);
    chk("release_cnt", {24'd0, term_cnt}, 32'd0);
    chk("release_rdy", {31'd0, in_rdy}, 32'd1);
    chk("release_vld", {31'd0, out_data_vld}, 32'd0);
    chk("release_keep", {16'd0, out_data}, {16'd0, held});
    chk("drop_sticky", {31'd0, drop_err}, 32'd1);
    in_data_vld = 1'b0;

    // Reset mid-frame after two terms
    @(negedge clk);
    in_data_vld = 1'b1; in_data = 21'h000100; in_last = 1'b0;
    @(negedge clk);
    in_data = 21'h000200;
    @(negedge clk);
    in_data_vld = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_data", {16'd0, out_data}, 32'd0);
    chk("mid_rst_cnt", {24'd0, term_cnt}, 32'd0);
    chk("mid_rst_ovf", {31'd0, acc_ovf}, 32'd0);
    chk("mid_rst_drop", {31'd0, drop_err}, 32'd0);
    chk("mid_rst_rdy", {31'd0, in_rdy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    terms = '{21'h000123};
    send_frame(terms, 1'b0, 1'b1, fin(16'h0123), 8'd1, 1'b0);

    // Saturating count, then a back-to-back frame
    terms.delete();
    for (int i = 0; i < 300; i++) terms.push_back(21'h000001);
    send_frame(terms, 1'b0, 1'b1, fin(16'h012C), 8'd255, 1'b0);
    terms = '{21'h000005};
    send_frame(terms, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    drain();

    // Random frames against the reference model
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      terms.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) terms.push_back(21'($urandom_range(0, 21'h1FFFFF)));
      send_frame(terms, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
    end
    @(negedge clk);
    rand_rdy = 1'b0;
    out_data_rdy = 1'b1;
    drain();
    chk("drop_final", {31'd0, drop_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
